fpu_unpacker16: RTL and testbench
=================================

Name: fpu_unpacker16

Overview:
- Operand front end for the half-precision FPU: turns a packed fp16_t into the unpacked internal form consumed by the add/sub and multiply datapaths.
- It is the inverse of the normalizer/packer stage: it classifies the operand, restores the hidden bit and unbiases the exponent.
- Denormals are pre-normalized by a multi-cycle left-shift FSM, so downstream logic always sees a leading 1.
- Valid/ready handshake on both sides; holds one operand.

Parameters:
SHIFT_PER_CYCLE, 1, maximum left-shift bits applied per normalization cycle (legal 1..10)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept an operand this cycle
in_data  input  16  fp16_t operand {sign, exp[4:0], frac[9:0]}
out_valid  output  1  unpacked result valid
out_ready  input  1  downstream accepts the result
out_sign  output  1  operand sign
out_exp  output  6  signed unbiased exponent (two's complement)
out_sig  output  11  significand with explicit leading bit
out_class  output  3  fpClass16_t: ZERO, DENORM, NORMAL, INF, QNAN, SNAN
out_lzc  output  4  left shifts applied during normalization (0 unless DENORM)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state:
  - State = IDLE; out_valid = 0; in_ready = 1 after reset release.
  - All data outputs = 0; out_class = ZERO.
- States:
  - IDLE: empty.
  - NORM: shifting a denormal.
  - HOLD: result presented.
- Handshakes:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - in_ready is low throughout NORM.
  - out_valid = (state==HOLD).
  - All out_* are stable while out_valid && !out_ready.
- Classification at acceptance (e = exp field, f = frac):
  - e==0, f==0 -> ZERO: out_exp 0, out_sig 0, go HOLD.
  - e==31, f==0 -> INF: out_exp 0, out_sig 0, go HOLD.
  - e==31, f!=0 -> QNAN if f[9] else SNAN: out_exp 0, out_sig {1'b1, f}, go HOLD.
  - 1<=e<=30 -> NORMAL: out_exp = e-15 (range -14..15), out_sig {1'b1, f}, go HOLD.
  - e==0, f!=0 -> DENORM: sig register = {1'b0, f}, exp register = -14, lzc = 0, go NORM.
- NORM cycle:
  - k = min(SHIFT_PER_CYCLE, leading zeros of sig register).
  - sig <<= k; exp -= k; lzc += k.
  - If the new sig[10]==1 -> HOLD, else stay in NORM.
- Latency (accept cycle = 0):
  - out_valid is asserted at cycle 1 for non-DENORM operands.
  - For a DENORM operand it is asserted at cycle 1 + ceil(n/SHIFT_PER_CYCLE), where n = leading zeros of {0, f} (1..10).
- Exponent and lzc ranges:
  - DENORM out_exp range is -15..-24; the 6-bit signed width covers -24..15 with no overflow.
  - out_lzc saturates naturally at 10 and never exceeds it.
- Throughput: 1 operand/cycle for non-DENORM streams with out_ready held high (HOLD -> HOLD on simultaneous output and input transfer).
- HOLD with output transfer and no new input -> IDLE.
- in_valid while in_ready is low: no acceptance, no state change. The source keeps in_data stable.
- Reset mid-NORM or mid-HOLD: the in-flight operand is discarded, and the block returns immediately to the reset state.

Decomposition:
- Shared package adds:
  - fpClass16_t enum (3 bits).
  - unpacked16_t struct {sign, logic signed [5:0] exp, logic [10:0] sig}.
  - Constants FP16_BIAS = 15, FP16_EXP_MAX = 31, FP16_UNPACK_EXPW = 6, FP16_SIGW = 11.
- One sub-module: fpu_lzc_window16.
  - Combinational leading-zero count of an 11-bit vector, clamped to SHIFT_PER_CYCLE.
  - Reusable later by the normalizer.

Test Plan:
- 0x3C00 accepted at cycle 0, out_ready=1 -> cycle 1: out_valid=1, NORMAL, sign 0, exp 0, sig 0x400, lzc 0. Stream 0x3C00, 0xC000, 0x7BFF back-to-back -> outputs on consecutive cycles: 0xC000 gives sign 1, exp 1, sig 0x400; 0x7BFF gives exp 15, sig 0x7FF.
- SHIFT_PER_CYCLE=1, 0x0001 -> in_ready low for cycles 1..10, out_valid at cycle 11: DENORM, exp -24, sig 0x400, lzc 10. 0x0200 -> out_valid at cycle 2: exp -15, lzc 1.
- SHIFT_PER_CYCLE=4, 0x0001 -> shifts 4, 4, 2, out_valid at cycle 4 with exp -24, lzc 10.
- Specials:
  - 0x8000 -> ZERO, sign 1.
  - 0x7C00 -> INF, sig 0.
  - 0x7E00 -> QNAN, sig 0x600.
  - 0x7D00 -> SNAN, sig 0x500.
  - 0xFC00 -> INF, sign 1.
- Backpressure: accept 0x3C00 with out_ready=0 for 3 cycles -> outputs frozen and in_ready=0 while out_ready=0. When out_ready rises, 0x4000 is accepted in the same cycle; the next cycle shows exp 1, sig 0x400.
- rst_n pulled low at cycle 5 while 0x0001 is in NORM -> out_valid=0 and outputs 0 immediately, with no clock edge. After release, in_ready=1, and 0x3C00 completes with 1-cycle latency.

Source files
------------

// File: rtl/fpu_unpacker16_pkg.sv
// Shared types and constants for the half-precision operand front end.
package fpu_unpacker16_pkg;

  localparam int FP16_BIAS        = 15;
  localparam logic [4:0] FP16_EXP_MAX = 5'd31;
  localparam int FP16_UNPACK_EXPW = 6;
  localparam int FP16_SIGW        = 11;

  // Operand classes as seen by the add/sub and multiply datapaths.
  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_QNAN   = 3'd4,
    CLS_SNAN   = 3'd5
  } fpClass16_t;

  // Unpacked operand: unbiased two's complement exponent, explicit leading bit.
  typedef struct packed {
    logic                                sign;
    logic signed [FP16_UNPACK_EXPW-1:0]  exp;
    logic        [FP16_SIGW-1:0]         sig;
  } unpacked16_t;

  // Unpacker control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_HOLD = 2'd2
  } unpState_t;

endpackage

// File: rtl/fpu_lzc_window16.sv
// Leading-zero count of an 11-bit vector, clamped to a per-cycle shift window.
module fpu_lzc_window16 #(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic [10:0] vec,
  output logic [3:0]  shiftAmt
);

  localparam logic [3:0] WINDOW = 4'(SHIFT_PER_CYCLE);

  logic [3:0] lzCount;

  // Highest set bit wins because later iterations overwrite; all-zero gives 11.
  always_comb begin
    lzCount = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (vec[i]) lzCount = 4'(10 - i);
    end
    shiftAmt = (lzCount > WINDOW) ? WINDOW : lzCount;
  end

endmodule

// File: rtl/fpu_unpacker16.sv
// Half-precision operand unpacker: classify, restore hidden bit, unbias the
// exponent, and pre-normalize denormals with a multi-cycle left shifter.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// in_ready is high in IDLE, or in HOLD when the held result leaves this same
// cycle; it is low throughout NORM. out_valid is high exactly in HOLD, and
// every out_* stays stable while out_valid && !out_ready.
module fpu_unpacker16
  import fpu_unpacker16_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic signed [5:0]  out_exp,
  output logic [10:0]        out_sig,
  output logic [2:0]         out_class,
  output logic [3:0]         out_lzc,
  output logic [1:0]         dbgState
);

  unpState_t   state, stateNext;
  unpacked16_t resReg, inRes;
  fpClass16_t  clsReg, inCls;
  logic [3:0]  lzcReg;
  logic [3:0]  shiftAmt;
  logic [10:0] shiftedSig;
  logic [4:0]  inExp;
  logic [9:0]  inFrac;
  logic        acceptIn;

  assign inExp      = in_data[14:10];
  assign inFrac     = in_data[9:0];
  assign acceptIn   = in_valid && in_ready;
  assign shiftedSig = resReg.sig << shiftAmt;

  fpu_lzc_window16 #(.SHIFT_PER_CYCLE(SHIFT_PER_CYCLE)) uLzc (
    .vec     (resReg.sig),
    .shiftAmt(shiftAmt)
  );

  // Classify the incoming operand and build its unpacked form.
  always_comb begin
    inRes.sign = in_data[15];
    inRes.exp  = '0;
    inRes.sig  = '0;
    inCls      = CLS_ZERO;
    if (inExp == 5'd0) begin
      if (inFrac != 10'd0) begin
        inCls     = CLS_DENORM;
        inRes.exp = -6'sd14;
        inRes.sig = {1'b0, inFrac};
      end
    end else if (inExp == FP16_EXP_MAX) begin
      if (inFrac == 10'd0) begin
        inCls = CLS_INF;
      end else begin
        inCls     = inFrac[9] ? CLS_QNAN : CLS_SNAN;
        inRes.sig = {1'b1, inFrac};
      end
    end else begin
      inCls     = CLS_NORMAL;
      inRes.exp = $signed({1'b0, inExp}) - $signed(6'(FP16_BIAS));
      inRes.sig = {1'b1, inFrac};
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Next state and handshake outputs.
  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (acceptIn) stateNext = (inCls == CLS_DENORM) ? ST_NORM : ST_HOLD;
      end
      ST_NORM: begin
        if (shiftedSig[10]) stateNext = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (acceptIn)       stateNext = (inCls == CLS_DENORM) ? ST_NORM : ST_HOLD;
        else if (out_ready) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Result registers: load on acceptance, shift left while normalizing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resReg <= '0;
      clsReg <= CLS_ZERO;
      lzcReg <= '0;
    end else if (acceptIn) begin
      resReg <= inRes;
      clsReg <= inCls;
      lzcReg <= '0;
    end else if (state == ST_NORM) begin
      resReg.sig <= shiftedSig;
      resReg.exp <= resReg.exp - $signed({2'b00, shiftAmt});
      lzcReg     <= lzcReg + shiftAmt;
    end
  end

  assign out_sign  = resReg.sign;
  assign out_exp   = resReg.exp;
  assign out_sig   = resReg.sig;
  assign out_class = clsReg;
  assign out_lzc   = lzcReg;
  assign dbgState  = state;

endmodule

// File: tb/tb_fpu_unpacker16.sv
// Directed bench for fpu_unpacker16 with hand-computed expectations.
module tb_fpu_unpacker16;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid, in_valid4, out_ready;
  logic [15:0]        in_data;
  logic               in_ready, out_valid, out_sign;
  logic signed [5:0]  out_exp;
  logic [10:0]        out_sig;
  logic [2:0]         out_class;
  logic [3:0]         out_lzc;
  logic [1:0]         dbgState;

  logic               in_ready4, out_valid4, out_sign4;
  logic signed [5:0]  out_exp4;
  logic [10:0]        out_sig4;
  logic [2:0]         out_class4;
  logic [3:0]         out_lzc4;
  logic [1:0]         dbgState4;

  fpu_unpacker16 #(.SHIFT_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
    .out_class(out_class), .out_lzc(out_lzc), .dbgState(dbgState)
  );

  fpu_unpacker16 #(.SHIFT_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_sign(out_sign4), .out_exp(out_exp4), .out_sig(out_sig4),
    .out_class(out_class4), .out_lzc(out_lzc4), .dbgState(dbgState4)
  );

  // Class codes and 6-bit two's complement exponents used below.
  localparam logic [2:0] C_ZERO = 3'd0, C_DEN = 3'd1, C_NORM = 3'd2,
                         C_INF = 3'd3, C_QNAN = 3'd4, C_SNAN = 3'd5;
  localparam logic [15:0] E_M24 = 16'h0028, E_M15 = 16'h0031;

  // ---- scoreboard counters ----
  int totalCnt = 0;
  int badCnt   = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    totalCnt++;
    if (got !== want) begin
      badCnt++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] sign, input logic [15:0] expv,
                           input logic [15:0] sig, input logic [15:0] cls, input logic [15:0] lzc);
    check_val({tag, ".valid"}, 16'(out_valid), 16'd1);
    check_val({tag, ".sign"},  16'(out_sign), sign);
    check_val({tag, ".exp"},   16'({10'd0, out_exp}), expv);
    check_val({tag, ".sig"},   16'(out_sig), sig);
    check_val({tag, ".class"}, 16'(out_class), cls);
    check_val({tag, ".lzc"},   16'(out_lzc), lzc);
  endtask

  // ---- driver helpers ----
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_special(input string tag, input logic [15:0] data, input logic [15:0] sign,
                              input logic [15:0] sig, input logic [15:0] cls);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    check_out(tag, sign, 16'd0, sig, cls, 16'd0);
    tick();
  endtask

  initial begin
    in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; in_data = 16'h0;

    // Reset state
    #12;
    check_val("rst.valid", 16'(out_valid), 16'd0);
    check_val("rst.sig",   16'(out_sig), 16'd0);
    check_val("rst.class", 16'(out_class), 16'(C_ZERO));
    check_val("rst.state", 16'(dbgState), 16'd0);
    rst_n = 1'b1;
    #10;
    check_val("rst.in_ready", 16'(in_ready), 16'd1);
    tick();

    // Back-to-back normals, one result per cycle
    in_valid = 1'b1; in_data = 16'h3C00;
    tick();
    check_out("s0", 16'd0, 16'd0, 16'h400, 16'(C_NORM), 16'd0);
    in_data = 16'hC000;
    tick();
    check_out("s1", 16'd1, 16'd1, 16'h400, 16'(C_NORM), 16'd0);
    in_data = 16'h7BFF;
    tick();
    check_out("s2", 16'd0, 16'd15, 16'h7FF, 16'(C_NORM), 16'd0);
    in_valid = 1'b0;
    tick();
    check_val("s.idle", 16'(out_valid), 16'd0);

    // Smallest denormal, one shift per cycle
    in_valid = 1'b1; in_data = 16'h0001;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check_val($sformatf("d1.rdy%0d", c), 16'(in_ready), 16'd0);
      check_val($sformatf("d1.vld%0d", c), 16'(out_valid), 16'd0);
      tick();
    end
    check_out("d1", 16'd0, E_M24, 16'h400, 16'(C_DEN), 16'd10);
    tick();

    // Denormal needing a single shift
    in_valid = 1'b1; in_data = 16'h0200;
    tick();
    in_valid = 1'b0;
    check_val("d2.vld1", 16'(out_valid), 16'd0);
    tick();
    check_out("d2", 16'd0, E_M15, 16'h400, 16'(C_DEN), 16'd1);
    tick();

    // Four-bit shift window: 4, 4, 2
    in_valid4 = 1'b1; in_data = 16'h0001;
    tick();
    in_valid4 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_val($sformatf("w4.vld%0d", c), 16'(out_valid4), 16'd0);
      tick();
    end
    check_val("w4.valid", 16'(out_valid4), 16'd1);
    check_val("w4.exp",   16'({10'd0, out_exp4}), E_M24);
    check_val("w4.sig",   16'(out_sig4), 16'h400);
    check_val("w4.class", 16'(out_class4), 16'(C_DEN));
    check_val("w4.lzc",   16'(out_lzc4), 16'd10);
    tick();

    // Specials
    send_special("negzero", 16'h8000, 16'd1, 16'h000, 16'(C_ZERO));
    send_special("inf",     16'h7C00, 16'd0, 16'h000, 16'(C_INF));
    send_special("qnan",    16'h7E00, 16'd0, 16'h600, 16'(C_QNAN));
    send_special("snan",    16'h7D00, 16'd0, 16'h500, 16'(C_SNAN));
    send_special("neginf",  16'hFC00, 16'd1, 16'h000, 16'(C_INF));

    // Backpressure: result frozen, input refused until out_ready rises
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h3C00;
    tick();
    in_data = 16'h4000;
    for (int c = 1; c <= 3; c++) begin
      check_out($sformatf("bp%0d", c), 16'd0, 16'd0, 16'h400, 16'(C_NORM), 16'd0);
      check_val($sformatf("bp%0d.rdy", c), 16'(in_ready), 16'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_val("bp.rdy_up", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
    check_out("bp.next", 16'd0, 16'd1, 16'h400, 16'(C_NORM), 16'd0);
    tick();

    // Asynchronous reset in the middle of normalization
    in_valid = 1'b1; in_data = 16'h0001;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    check_val("ar.busy", 16'(in_ready), 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar.valid", 16'(out_valid), 16'd0);
    check_val("ar.sig",   16'(out_sig), 16'd0);
    check_val("ar.exp",   16'({10'd0, out_exp}), 16'd0);
    check_val("ar.lzc",   16'(out_lzc), 16'd0);
    check_val("ar.class", 16'(out_class), 16'(C_ZERO));
    #10;
    rst_n = 1'b1;
    #1;
    check_val("ar.rdy", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b1; in_data = 16'h3C00;
    tick();
    in_valid = 1'b0;
    check_out("ar.after", 16'd0, 16'd0, 16'h400, 16'(C_NORM), 16'd0);
    tick();

    // ---- final report ----
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
